// File: rtl/weight_loader_if.sv
// Weight-load bus: the host/DMA weight stream in, plus the write port into the CNN weight memory.
interface weight_loader_if #(
    parameter int WEIGHT_WIDTH = 8,
    parameter int AW           = 7
);
    logic [WEIGHT_WIDTH-1:0] s_data;
    logic                    s_valid;
    logic                    s_ready;
    logic                    load_enable;
    logic [AW-1:0]           load_addr;
    logic [WEIGHT_WIDTH-1:0] load_data;
    logic                    load_valid;
    logic                    load_done;

    modport master (
        input  s_data, s_valid, load_done,
        output s_ready, load_enable, load_addr, load_data, load_valid
    );

    modport slave (
        output s_data, s_valid, load_done,
        input  s_ready, load_enable, load_addr, load_data, load_valid
    );
endinterface

// File: rtl/weight_loader.sv
// Streams TOTAL weights into the CNN weight memory with sequential addresses and waits for load_done.
// Optional trailing checksum word: define WEIGHT_LOADER_CHECKSUM_EN.
module weight_loader #(
    parameter int NUM_FILTERS    = 64,
    parameter int INPUT_CHANNELS = 3,
    parameter int KERNEL_SIZE    = 3,
    parameter int WEIGHT_WIDTH   = 8,
    parameter int DONE_TIMEOUT   = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic error,
    weight_loader_if.master bus
);
    localparam int TOTAL = NUM_FILTERS * INPUT_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
    localparam int AW    = $clog2(TOTAL);
    localparam int TW    = $clog2(DONE_TIMEOUT + 1);

    localparam logic [AW-1:0] LAST_ADDR = AW'(TOTAL - 1);
    localparam logic [TW-1:0] LAST_WAIT = TW'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        STREAM,
        CHECK,
        WAIT_DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic [TW-1:0] tcnt;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [WEIGHT_WIDTH-1:0] acc;

    // Checksum is the plain sum of weights, wrapping modulo 2^WEIGHT_WIDTH.
    function automatic logic [WEIGHT_WIDTH-1:0] csum_add(input logic [WEIGHT_WIDTH-1:0] a,
                                                         input logic [WEIGHT_WIDTH-1:0] b);
        return a + b;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            tcnt            <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            bus.s_ready     <= 1'b0;
            bus.load_enable <= 1'b0;
            bus.load_addr   <= '0;
            bus.load_data   <= '0;
            bus.load_valid  <= 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            acc             <= '0;
`endif
        end else begin
            done           <= 1'b0;
            bus.load_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state           <= ARM;
                        error           <= 1'b0;
                        cnt             <= '0;
                        tcnt            <= '0;
                        busy            <= 1'b1;
                        bus.load_enable <= 1'b1;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                        acc             <= '0;
`endif
                    end
                end

                // One quiet cycle so the memory sees the session open before the first write.
                ARM: begin
                    state       <= STREAM;
                    bus.s_ready <= 1'b1;
                end

                STREAM: begin
                    if (bus.s_valid && bus.s_ready) begin
                        bus.load_valid <= 1'b1;
                        bus.load_addr  <= cnt;
                        bus.load_data  <= bus.s_data;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                        acc            <= csum_add(acc, bus.s_data);
`endif
                        // Counter holds at the last address rather than wrapping.
                        if (cnt == LAST_ADDR) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                            state       <= CHECK;
`else
                            state       <= WAIT_DONE;
                            bus.s_ready <= 1'b0;
                            tcnt        <= '0;
`endif
                        end else begin
                            cnt <= cnt + AW'(1);
                        end
                    end
                end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (bus.s_valid && bus.s_ready) begin
                        bus.s_ready <= 1'b0;
                        if (bus.s_data == acc) begin
                            state <= WAIT_DONE;
                            tcnt  <= '0;
                        end else begin
                            state           <= IDLE;
                            error           <= 1'b1;
                            busy            <= 1'b0;
                            bus.load_enable <= 1'b0;
                        end
                    end
                end
`endif

                WAIT_DONE: begin
                    if (bus.load_done) begin
                        state           <= IDLE;
                        done            <= 1'b1;
                        busy            <= 1'b0;
                        bus.load_enable <= 1'b0;
                    end else if (tcnt == LAST_WAIT) begin
                        state           <= IDLE;
                        error           <= 1'b1;
                        busy            <= 1'b0;
                        bus.load_enable <= 1'b0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                default: begin
                    state           <= IDLE;
                    busy            <= 1'b0;
                    bus.s_ready     <= 1'b0;
                    bus.load_enable <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_weight_loader.sv
// Randomized bench for weight_loader: expected writes, checksum and timing come from a plain array model.
module tb_weight_loader;
    localparam int NF    = 4;
    localparam int IC    = 3;
    localparam int KS    = 3;
    localparam int WW    = 8;
    localparam int TMO   = 64;
    localparam int TOTAL = NF * IC * KS * KS;
    localparam int AW    = $clog2(TOTAL);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    localparam int CK_EXTRA = 1;
`else
    localparam int CK_EXTRA = 0;
`endif
    localparam int NW = TOTAL + CK_EXTRA;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic error;

    weight_loader_if #(.WEIGHT_WIDTH(WW), .AW(AW)) bus ();

    weight_loader #(
        .NUM_FILTERS   (NF),
        .INPUT_CHANNELS(IC),
        .KERNEL_SIZE   (KS),
        .WEIGHT_WIDTH  (WW),
        .DONE_TIMEOUT  (TMO)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .busy (busy),
        .done (done),
        .error(error),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;
    int ncyc = 0;
    int last_lv = 0;
    int err_cyc = -1;
    int done_cnt = 0;
    logic [WW-1:0] wt [0:TOTAL];
    logic [AW-1:0] wa_q [$];
    logic [WW-1:0] wd_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and record what the memory side saw.
    task automatic tick();
        @(negedge clk);
        ncyc++;
        if (bus.load_valid === 1'b1) begin
            wa_q.push_back(bus.load_addr);
            wd_q.push_back(bus.load_data);
            last_lv = ncyc;
        end
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1 && err_cyc < 0) err_cyc = ncyc;
    endtask

    task automatic clear_obs();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
        err_cyc = -1;
    endtask

    task automatic set_ck(input int bad);
        int s = 0;
        for (int i = 0; i < TOTAL; i++) s += int'(wt[i]);
        wt[TOTAL] = WW'((s + bad) % (1 << WW));
    endtask

    task automatic run_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("arm_busy", 32'(busy), 32'd1);
        check("arm_enable", 32'(bus.load_enable), 32'd1);
        check("arm_ready", 32'(bus.s_ready), 32'd0);
        check("arm_valid", 32'(bus.load_valid), 32'd0);
        check("arm_error_clr", 32'(error), 32'd0);
    endtask

    task automatic stream(input int gap, input int start_at, input int rst_at,
                          input int ld_at, output bit aborted);
        int idx = 0;
        int budget = 0;
        logic rdy;
        logic v;
        aborted = 1'b0;
        while (idx < NW && budget < 3000) begin
            if (idx == rst_at) begin
                start = 1'b0;
                bus.load_done = 1'b0;
                bus.s_valid = 1'b0;
                rst = 1'b1;
                tick();
                rst = 1'b0;
                aborted = 1'b1;
                return;
            end
            start = (idx == start_at);
            bus.load_done = (idx == ld_at);
            rdy = bus.s_ready;
            v = ($urandom_range(0, 99) >= gap);
            bus.s_valid = v;
            bus.s_data = wt[idx];
            tick();
            if (v && rdy) idx++;
            budget++;
        end
        start = 1'b0;
        bus.load_done = 1'b0;
        bus.s_valid = 1'b0;
        check("stream_words", 32'(idx), 32'(NW));
    endtask

    // Extra beats are offered while waiting; none may be accepted.
    task automatic finish_load(input int delay);
        for (int i = 0; i < delay; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data = WW'($urandom);
            tick();
        end
        bus.s_valid = 1'b0;
        check("wait_ready", 32'(bus.s_ready), 32'd0);
        check("wait_no_done", 32'(done_cnt), 32'd0);
        bus.load_done = 1'b1;
        tick();
        bus.load_done = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("done_enable", 32'(bus.load_enable), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("done_error", 32'(error), 32'd0);
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("done_count", 32'(done_cnt), 32'd1);
    endtask

    task automatic verify_writes();
        check("write_count", 32'(wa_q.size()), 32'(TOTAL));
        for (int i = 0; i < TOTAL && i < wa_q.size(); i++) begin
            check($sformatf("addr[%0d]", i), 32'(wa_q[i]), 32'(i));
            check($sformatf("data[%0d]", i), 32'(wd_q[i]), 32'(wt[i]));
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_enable"}, 32'(bus.load_enable), 32'd0);
        check({tag, "_valid"}, 32'(bus.load_valid), 32'd0);
        check({tag, "_ready"}, 32'(bus.s_ready), 32'd0);
        check({tag, "_addr"}, 32'(bus.load_addr), 32'd0);
        check({tag, "_data"}, 32'(bus.load_data), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ab;
        int waited;
        rst = 1'b1;
        start = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.load_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_idle_zero("reset");

        // Ramp data 1..TOTAL, no gaps.
        for (int i = 0; i < TOTAL; i++) wt[i] = WW'((i % 256) + 1);
        set_ck(0);
        clear_obs();
        run_start();
        stream(0, -1, -1, -1, ab);
        finish_load(5);
        verify_writes();

        // Random data with ~30% gaps; load_done coincides with the last write.
        for (int i = 0; i < TOTAL; i++) wt[i] = WW'($urandom);
        set_ck(0);
        clear_obs();
        run_start();
        stream(30, -1, -1, -1, ab);
        check("last_write_now", 32'(last_lv), 32'(ncyc - CK_EXTRA));
        finish_load(0);
        verify_writes();

        // Memory never answers: timeout.
        clear_obs();
        run_start();
        stream(0, -1, -1, -1, ab);
        waited = 0;
        while (err_cyc < 0 && waited < 200) begin
            tick();
            waited++;
        end
        check("timeout_seen", 32'(err_cyc >= 0), 32'd1);
        check("timeout_cycles", 32'(err_cyc - last_lv), 32'(TMO + CK_EXTRA));
        check("timeout_enable", 32'(bus.load_enable), 32'd0);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_no_done", 32'(done_cnt), 32'd0);
        tick();
        check("timeout_sticky", 32'(error), 32'd1);

        // start pulsed mid-stream is ignored.
        for (int i = 0; i < TOTAL; i++) wt[i] = WW'($urandom);
        set_ck(0);
        clear_obs();
        run_start();
        stream(10, 50, -1, -1, ab);
        finish_load(2);
        verify_writes();

        // rst mid-stream, then a clean restart from address 0.
        clear_obs();
        run_start();
        stream(0, -1, 50, -1, ab);
        check("rst_aborted", 32'(ab), 32'd1);
        check_idle_zero("midrst");
        for (int i = 0; i < TOTAL; i++) wt[i] = WW'($urandom);
        set_ck(0);
        clear_obs();
        run_start();
        stream(0, -1, -1, -1, ab);
        finish_load(1);
        verify_writes();

        // load_done during the stream is ignored.
        clear_obs();
        run_start();
        stream(20, -1, -1, 60, ab);
        check("early_ld_busy", 32'(busy), 32'd1);
        check("early_ld_no_done", 32'(done_cnt), 32'd0);
        finish_load(3);
        verify_writes();

`ifdef WEIGHT_LOADER_CHECKSUM_EN
        // Wrong trailing checksum: error, no done.
        for (int i = 0; i < TOTAL; i++) wt[i] = WW'($urandom);
        set_ck(1);
        clear_obs();
        run_start();
        stream(0, -1, -1, -1, ab);
        tick();
        bus.load_done = 1'b1;
        tick();
        bus.load_done = 1'b0;
        tick();
        check("badck_error", 32'(error), 32'd1);
        check("badck_no_done", 32'(done_cnt), 32'd0);
        check("badck_busy", 32'(busy), 32'd0);
        check("badck_enable", 32'(bus.load_enable), 32'd0);
        check("badck_writes", 32'(wa_q.size()), 32'(TOTAL));
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
